friscv_bomba_driver: RTL and testbench

Pump-side driver for the Frisc-V juice dispenser: receives one pump activation request from the Frisc-V controller, runs the pump for a timed dose and returns a completion/fault handshake. One instance per pump (bomba 1, bomba 2). It sits between the controller's `ativa_bomba_N` output and the physical pump MOSFET gate.

---
 rtl/friscv_bomba_driver.sv | 140 ++++++++++++++
 tb/tb_friscv_bomba_driver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_bomba_driver.sv
// Pump driver for one Frisc-V dispenser pump: accepts a 4-phase request, pours a timed dose, then acknowledges or flags an empty reservoir.
// Optional soft-start PWM ramp is enabled by defining BOMBA_RAMP_EN.
module friscv_bomba_driver #(
  parameter int TICK_DIV = 50000,
  parameter int RAMP_INC = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ativa_bomba,
  input  logic [15:0] dose_ms,
  input  logic        sensor_vazio,
  output logic        bomba_pwm,
  output logic        bomba_ocupada,
  output logic        dose_concluida,
  output logic        erro_vazio
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, POUR, DONE, FAULT} state_t;

  state_t        state, next_state;
  logic          vazio_meta, vazio_s;
  logic          armed;
  logic          accept;
  logic          tick;
  logic [PW-1:0] presc;
  logic [15:0]   restante;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vazio_meta <= 1'b0;
      vazio_s    <= 1'b0;
    end else begin
      vazio_meta <= sensor_vazio;
      vazio_s    <= vazio_meta;
    end
  end

  assign tick = (state == POUR) && (presc == PRESC_LAST);

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (ativa_bomba && armed) begin
          if (vazio_s)              next_state = FAULT;
          else if (dose_ms == 16'd0) next_state = DONE;
          else begin
            next_state = POUR;
            accept     = 1'b1;
          end
        end
      end
      POUR: begin
        // Abort beats fault, fault beats completion.
        if (!ativa_bomba)                      next_state = IDLE;
        else if (vazio_s)                      next_state = FAULT;
        else if (tick && (restante == 16'd1))  next_state = DONE;
      end
      DONE, FAULT: begin
        if (!ativa_bomba) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A request only counts once the line has been seen low while idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      armed    <= 1'b0;
      presc    <= '0;
      restante <= 16'd0;
    end else begin
      state <= next_state;
      if (state != IDLE)     armed <= 1'b0;
      else if (!ativa_bomba) armed <= 1'b1;

      if (accept) begin
        presc    <= '0;
        restante <= dose_ms;
      end else if (state == POUR) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick && (restante != 16'd0)) restante <= restante - 16'd1;
      end
    end
  end

`ifdef BOMBA_RAMP_EN
  logic [7:0] pwm_cnt;
  logic [7:0] duty, duty_nxt;
  logic [8:0] duty_sum;

  assign duty_sum = {1'b0, duty} + 9'(RAMP_INC);

  always_comb begin
    duty_nxt = duty;
    if (accept)    duty_nxt = 8'd0;
    else if (tick) duty_nxt = duty_sum[8] ? 8'hFF : duty_sum[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= 8'd0;
      duty    <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      duty    <= duty_nxt;
    end
  end

  // Saturated duty forces a solid-on gate instead of a 255/256 waveform.
  logic pwm_level;
  assign pwm_level = (duty_nxt == 8'hFF) || (pwm_cnt < duty_nxt);
`else
  logic pwm_level;
  assign pwm_level = 1'b1;
`endif

  // Outputs are registered from next_state so they move on the same edge as the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bomba_pwm      <= 1'b0;
      bomba_ocupada  <= 1'b0;
      dose_concluida <= 1'b0;
      erro_vazio     <= 1'b0;
    end else begin
      bomba_pwm      <= (next_state == POUR) && pwm_level;
      bomba_ocupada  <= (next_state == POUR);
      dose_concluida <= (next_state == DONE);
      erro_vazio     <= (next_state == FAULT);
    end
  end

endmodule

// File: tb/tb_friscv_bomba_driver.sv
// Directed self-checking bench for friscv_bomba_driver with TICK_DIV=4 (RAMP_INC=64 for the soft-start build).
module tb_friscv_bomba_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic        ativa_bomba;
  logic [15:0] dose_ms;
  logic        sensor_vazio;
  logic        bomba_pwm, bomba_ocupada, dose_concluida, erro_vazio;
  logic        pump_on;

  int checks = 0;
  int errors = 0;

  friscv_bomba_driver #(.TICK_DIV(4), .RAMP_INC(64)) dut (
    .clock          (clock),
    .reset          (reset),
    .ativa_bomba    (ativa_bomba),
    .dose_ms        (dose_ms),
    .sensor_vazio   (sensor_vazio),
    .bomba_pwm      (bomba_pwm),
    .bomba_ocupada  (bomba_ocupada),
    .dose_concluida (dose_concluida),
    .erro_vazio     (erro_vazio)
  );

  always #5 clock = ~clock;

`ifdef BOMBA_RAMP_EN
  assign pump_on = bomba_ocupada;
`else
  assign pump_on = bomba_pwm;
`endif

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; ativa_bomba = 1'b0; dose_ms = 16'd0; sensor_vazio = 1'b0;
    #3;
    checks++;
    if ({bomba_pwm, bomba_ocupada, dose_concluida, erro_vazio} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {bomba_pwm, bomba_ocupada, dose_concluida, erro_vazio});
    end
    cyc(2);
    reset = 1'b1;
    cyc(3);
  endtask

  task automatic test_normal;
    int first_hi = -1;
    int hi_cnt = 0;
    logic done13 = 1'b0, pwm13 = 1'b1;
    dose_ms = 16'd3; ativa_bomba = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      if (i == 3) dose_ms = 16'd1;  // must be ignored after acceptance
      if (pump_on) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
      end
      if (i == 13) begin done13 = dose_concluida; pwm13 = pump_on; end
    end
    checks++;
    if (first_hi != 1) begin errors++; $display("FAIL normal_start: got %0d expected 1", first_hi); end
    checks++;
    if (hi_cnt != 12) begin errors++; $display("FAIL normal_len: got %0d expected 12", hi_cnt); end
    checks++;
    if ({done13, pwm13} !== 2'b10) begin errors++; $display("FAIL normal_done_edge: got %b expected 10", {done13, pwm13}); end
    checks++;
    if (dose_concluida !== 1'b1) begin errors++; $display("FAIL normal_done_held: got %b expected 1", dose_concluida); end
    ativa_bomba = 1'b0;
    cyc(1);
    checks++;
    if ({dose_concluida, bomba_ocupada, bomba_pwm} !== 3'b000) begin
      errors++; $display("FAIL normal_release: got %b expected 000", {dose_concluida, bomba_ocupada, bomba_pwm});
    end
    cyc(2);
  endtask

  task automatic test_zero;
    logic any_pwm = 1'b0;
    dose_ms = 16'd0; ativa_bomba = 1'b1;
    cyc(1);
    checks++;
    if ({dose_concluida, bomba_pwm} !== 2'b10) begin errors++; $display("FAIL zero_done: got %b expected 10", {dose_concluida, bomba_pwm}); end
    for (int i = 0; i < 5; i++) begin cyc(1); any_pwm |= bomba_pwm | bomba_ocupada; end
    checks++;
    if (any_pwm !== 1'b0) begin errors++; $display("FAIL zero_no_pulse: got %b expected 0", any_pwm); end
    ativa_bomba = 1'b0;
    cyc(1);
    checks++;
    if (dose_concluida !== 1'b0) begin errors++; $display("FAIL zero_release: got %b expected 0", dose_concluida); end
    cyc(2);
  endtask

  task automatic test_abort;
    logic any_done = 1'b0;
    dose_ms = 16'd10; ativa_bomba = 1'b1;
    cyc(5);
    checks++;
    if (bomba_ocupada !== 1'b1) begin errors++; $display("FAIL abort_running: got %b expected 1", bomba_ocupada); end
    ativa_bomba = 1'b0;
    cyc(1);
    checks++;
    if ({bomba_pwm, bomba_ocupada} !== 2'b00) begin errors++; $display("FAIL abort_off: got %b expected 00", {bomba_pwm, bomba_ocupada}); end
    any_done = dose_concluida | erro_vazio;
    for (int i = 0; i < 50; i++) begin cyc(1); any_done |= dose_concluida | erro_vazio | bomba_pwm; end
    checks++;
    if (any_done !== 1'b0) begin errors++; $display("FAIL abort_no_ack: got %b expected 0", any_done); end
  endtask

  task automatic test_fault_mid;
    dose_ms = 16'd10; ativa_bomba = 1'b1;
    cyc(3);
    sensor_vazio = 1'b1;
    cyc(2);
    checks++;
    if (bomba_ocupada !== 1'b1) begin errors++; $display("FAIL fault_latency_early: got %b expected 1", bomba_ocupada); end
    cyc(1);
    checks++;
    if ({bomba_pwm, bomba_ocupada, erro_vazio} !== 3'b001) begin
      errors++; $display("FAIL fault_off: got %b expected 001", {bomba_pwm, bomba_ocupada, erro_vazio});
    end
    sensor_vazio = 1'b0;
    cyc(6);
    checks++;
    if ({erro_vazio, bomba_ocupada} !== 2'b10) begin errors++; $display("FAIL fault_held: got %b expected 10", {erro_vazio, bomba_ocupada}); end
    ativa_bomba = 1'b0;
    cyc(1);
    checks++;
    if (erro_vazio !== 1'b0) begin errors++; $display("FAIL fault_release: got %b expected 0", erro_vazio); end
    cyc(2);
  endtask

  task automatic test_fault_direct;
    logic any_pwm = 1'b0;
    sensor_vazio = 1'b1;
    cyc(3);
    dose_ms = 16'd5; ativa_bomba = 1'b1;
    cyc(1);
    checks++;
    if ({erro_vazio, bomba_pwm, bomba_ocupada} !== 3'b100) begin
      errors++; $display("FAIL fault_direct: got %b expected 100", {erro_vazio, bomba_pwm, bomba_ocupada});
    end
    for (int i = 0; i < 4; i++) begin cyc(1); any_pwm |= bomba_pwm | bomba_ocupada; end
    checks++;
    if (any_pwm !== 1'b0) begin errors++; $display("FAIL fault_direct_no_pulse: got %b expected 0", any_pwm); end
    ativa_bomba = 1'b0; sensor_vazio = 1'b0;
    cyc(1);
    checks++;
    if (erro_vazio !== 1'b0) begin errors++; $display("FAIL fault_direct_release: got %b expected 0", erro_vazio); end
    cyc(3);
  endtask

  // Final tick, vazio_s and (optionally) the request drop all land in the same cycle.
  task automatic test_simultaneous(input logic drop);
    dose_ms = 16'd1; ativa_bomba = 1'b1;
    cyc(2);
    sensor_vazio = 1'b1;
    cyc(2);
    checks++;
    if (bomba_ocupada !== 1'b1) begin errors++; $display("FAIL simul_pre_%0d: got %b expected 1", drop, bomba_ocupada); end
    if (drop) ativa_bomba = 1'b0;
    cyc(1);
    checks++;
    if ({bomba_ocupada, dose_concluida, erro_vazio} !== {2'b00, ~drop}) begin
      errors++; $display("FAIL simul_outcome_%0d: got %b expected %b", drop,
                         {bomba_ocupada, dose_concluida, erro_vazio}, {2'b00, ~drop});
    end
    sensor_vazio = 1'b0; ativa_bomba = 1'b0;
    cyc(4);
  endtask

  task automatic test_max_dose;
    dose_ms = 16'hFFFF; ativa_bomba = 1'b1;
    cyc(1);
    checks++;
    if ({bomba_ocupada, dose_concluida} !== 2'b10) begin errors++; $display("FAIL max_start: got %b expected 10", {bomba_ocupada, dose_concluida}); end
    cyc(40);
    checks++;
    if ({bomba_ocupada, dose_concluida} !== 2'b10) begin errors++; $display("FAIL max_running: got %b expected 10", {bomba_ocupada, dose_concluida}); end
    ativa_bomba = 1'b0;
    cyc(3);
  endtask

  task automatic test_reset_mid;
    dose_ms = 16'd8; ativa_bomba = 1'b1;
    cyc(6);
    reset = 1'b0;
    #1;
    checks++;
    if ({bomba_pwm, bomba_ocupada, dose_concluida, erro_vazio} !== 4'b0000) begin
      errors++; $display("FAIL reset_mid: got %b expected 0000", {bomba_pwm, bomba_ocupada, dose_concluida, erro_vazio});
    end
    ativa_bomba = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(3);
  endtask

`ifdef BOMBA_RAMP_EN
  task automatic test_ramp;
    int ocup_cnt = 0;
    logic early_pwm = 1'b0;
    logic late_pwm = 1'b1;
    dose_ms = 16'd8; ativa_bomba = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      cyc(1);
      if (bomba_ocupada) ocup_cnt++;
      if (i <= 4) early_pwm |= bomba_pwm;
      if (i >= 17 && i <= 32) late_pwm &= bomba_pwm;
    end
    checks++;
    if (ocup_cnt != 32) begin errors++; $display("FAIL ramp_len: got %0d expected 32", ocup_cnt); end
    checks++;
    if (early_pwm !== 1'b0) begin errors++; $display("FAIL ramp_duty0: got %b expected 0", early_pwm); end
    checks++;
    if (late_pwm !== 1'b1) begin errors++; $display("FAIL ramp_saturated: got %b expected 1", late_pwm); end
    ativa_bomba = 1'b0;
    cyc(3);
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_zero();
    test_abort();
    test_fault_mid();
    test_fault_direct();
    test_simultaneous(1'b1);
    test_simultaneous(1'b0);
    test_max_dose();
    test_reset_mid();
`ifdef BOMBA_RAMP_EN
    test_ramp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
